// File: rtl/nibble_add_seq_if.sv
`default_nettype none
// nibble_add_seq_if: start/operand request and result/flag response bundle.
// Revision: 1.0
interface nibble_add_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, cout, overflow, zero
  );
endinterface
`default_nettype wire

// File: rtl/nibble_add_seq.sv
`default_nettype none
// nibble_add_seq: W-bit add/subtract built from one 4-bit ripple adder, one nibble per clock.
// Revision: 1.0

module serial_adder_4bit (
  input  wire logic [3:0] a_i,
  input  wire logic [3:0] b_i,
  input  wire logic       cin_i,
  output logic      [3:0] sum_o,
  output logic            cout_o
);
  logic [4:0] w_c;

  assign w_c[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
    assign w_c[i + 1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = w_c[4];
endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  nibble_add_seq_if.slave bus
);
  localparam int c_w  = 4 * NIBBLES;
  localparam int c_iw = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_iw-1:0] c_last = c_iw'(NIBBLES - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [c_w-1:0]  a_q,      a_d;
  logic [c_w-1:0]  bpr_q,    bpr_d;
  logic            carry_q,  carry_d;
  logic [c_iw-1:0] idx_q,    idx_d;
  logic [c_w-1:0]  result_q, result_d;
  logic            cout_q,   cout_d;
  logic            ovf_q,    ovf_d;
  logic            zero_q,   zero_d;

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [3:0] w_sum;
  logic       w_cout;

  assign w_a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign w_b_nib = bpr_q[{idx_q, 2'b00} +: 4];

  serial_adder_4bit u_adder (
    .a_i    (w_a_nib),
    .b_i    (w_b_nib),
    .cin_i  (carry_q),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= c_st_idle;
      a_q      <= '0;
      bpr_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      bpr_q    <= bpr_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    bpr_d    = bpr_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      c_st_idle, c_st_done: begin
        state_d = c_st_idle;
        // Subtraction is a + ~b + 1: invert b once here and seed the carry.
        if (bus.start) begin
          state_d  = c_st_run;
          a_d      = bus.a;
          bpr_d    = bus.op_sub ? ~bus.b : bus.b;
          carry_d  = bus.op_sub;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
        end
      end
      c_st_run: begin
        result_d[{idx_q, 2'b00} +: 4] = w_sum;
        carry_d = w_cout;
        idx_d   = idx_q + c_iw'(1);
        if (idx_q == c_last) begin
          state_d = c_st_done;
          idx_d   = '0;
          cout_d  = w_cout;
          ovf_d   = (a_q[c_w-1] == bpr_q[c_w-1]) && (w_sum[3] != a_q[c_w-1]);
          zero_d  = (result_d == '0);
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      c_st_run:  bus.busy = 1'b1;
      c_st_done: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
`default_nettype none
// tb_nibble_add_seq: drives a 4-nibble and a 2-nibble instance with shared stimulus and
// checks both against a transaction-level arithmetic model every cycle.
module tb_nibble_add_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  nibble_add_seq_if #(.W(16)) bus4 ();
  nibble_add_seq_if #(.W(8))  bus2 ();

  assign bus4.start  = start;
  assign bus4.op_sub = op_sub;
  assign bus4.a      = a;
  assign bus4.b      = b;
  assign bus2.start  = start;
  assign bus2.op_sub = op_sub;
  assign bus2.a      = a[7:0];
  assign bus2.b      = b[7:0];

  nibble_add_seq #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  nibble_add_seq #(.NIBBLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Transaction model: index 0 is the 4-nibble instance, index 1 the 2-nibble one.
  bit     m_busy[2], m_done[2], m_c[2], m_v[2], m_z[2];
  bit     p_c[2], p_v[2], p_z[2];
  longint m_res[2], p_res[2];
  int     m_cnt[2];

  function automatic int nn(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic model_step(input int d);
    longint w, modv, half, ua, ub, sa, sb, sr, full;
    w    = 4 * nn(d);
    modv = longint'(1) << w;
    half = modv / 2;
    if (rst) begin
      m_busy[d] = 0; m_done[d] = 0; m_c[d] = 0; m_v[d] = 0; m_z[d] = 0;
      m_res[d]  = 0; m_cnt[d]  = 0;
    end else if (!m_busy[d] && start) begin
      ua = longint'(a) % modv;
      ub = longint'(b) % modv;
      sa = (ua >= half) ? ua - modv : ua;
      sb = (ub >= half) ? ub - modv : ub;
      if (!op_sub) begin
        full   = ua + ub;
        p_c[d] = (full >= modv);
        sr     = sa + sb;
      end else begin
        full   = ua - ub + modv;
        p_c[d] = (ua >= ub);
        sr     = sa - sb;
      end
      p_res[d] = full % modv;
      p_v[d]   = (sr >= half) || (sr < -half);
      p_z[d]   = (p_res[d] == 0);
      m_res[d] = 0; m_c[d] = 0; m_v[d] = 0; m_z[d] = 0;
      m_busy[d] = 1; m_done[d] = 0; m_cnt[d] = nn(d);
    end else if (m_busy[d]) begin
      m_cnt[d] = m_cnt[d] - 1;
      m_res[d] = p_res[d] % (longint'(1) << (4 * (nn(d) - m_cnt[d])));
      if (m_cnt[d] == 0) begin
        m_busy[d] = 0; m_done[d] = 1;
        m_c[d] = p_c[d]; m_v[d] = p_v[d]; m_z[d] = p_z[d];
      end
    end else begin
      m_done[d] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  task automatic cmp(input string nm, input int d, input logic bz, input logic dn,
                     input logic [15:0] r, input logic c, input logic v, input logic z);
    logic [15:0] er;
    er = 16'(m_res[d]);
    total++;
    if ({bz, dn, r, c, v, z} !== {m_busy[d], m_done[d], er, m_c[d], m_v[d], m_z[d]}) begin
      bad++;
      $display("FAIL %s t=%0t got busy=%b done=%b res=%h c=%b v=%b z=%b want busy=%b done=%b res=%h c=%b v=%b z=%b",
               nm, $time, bz, dn, r, c, v, z, m_busy[d], m_done[d], er, m_c[d], m_v[d], m_z[d]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("dut4", 0, bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.overflow, bus4.zero);
      cmp("dut2", 1, bus2.busy, bus2.done, {8'h00, bus2.result}, bus2.cout, bus2.overflow, bus2.zero);
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // One operation on both instances, timed against the 4-nibble one.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input bit isub,
                        input bit lit, input logic [15:0] er, input bit ec, input bit ev,
                        input bit ez);
    int t;
    @(negedge clk);
    a = ia; b = ib; op_sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
    t = 1;
    while (bus4.done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("latency", t, 5);
    if (lit) begin
      check("result", {16'h0, bus4.result}, {16'h0, er});
      check("flags", {29'h0, bus4.cout, bus4.overflow, bus4.zero}, {29'h0, ec, ev, ez});
    end
    @(negedge clk);
    if (lit) check("done_width", {31'h0, bus4.done}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, cnt, last;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_outs", {bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.overflow, bus4.zero}, 32'h0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0FFF, 0, 1, 16'h2233, 0, 0, 0);
    run_op(16'hFFFF, 16'h0001, 0, 1, 16'h0000, 1, 0, 1);
    run_op(16'h7FFF, 16'h0001, 0, 1, 16'h8000, 0, 1, 0);
    run_op(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0);
    run_op(16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1, 0);
    run_op(16'h1234, 16'h1234, 1, 1, 16'h0000, 1, 0, 1);

    // Start during busy must be ignored.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; op_sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (bus4.done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("busy_ignore_res", {16'h0, bus4.result}, 32'h3333);
    repeat (4) @(negedge clk);

    // Start held high: re-accepted in every DONE cycle.
    a = 16'h0102; b = 16'h0304; op_sub = 1'b0; start = 1'b1;
    cnt = 0; last = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus4.done === 1'b1) begin
        cnt++;
        last = i;
      end
    end
    start = 1'b0;
    check("b2b_count", cnt, 3);
    check("b2b_last", last, 15);
    repeat (8) @(negedge clk);

    // Reset two cycles after start aborts the operation.
    a = 16'h1234; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outs", {bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.overflow, bus4.zero}, 32'h0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.done === 1'b1) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run_op(16'h00FF, 16'h0001, 0, 1, 16'h0100, 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 0, 16'h0, 0, 0, 0);
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
